fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000013, instruction placed on id_instr at reset and on fault.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 PC  input  32  current fetch address from the program counter register.
REQ-005 nextPC  output  32  next fetch address fed back to the program counter register; combinational.
REQ-006 imem_req  output  1  instruction memory request valid.
REQ-007 imem_addr  output  32  request address.
REQ-008 imem_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid  input  1  read data valid.
REQ-010 imem_rdata  input  32  read data.
REQ-011 id_valid  output  1  instruction valid to decode; registered.
REQ-012 id_instr  output  32  fetched instruction; registered.
REQ-013 id_pc  output  32  address of id_instr; registered.
REQ-014 id_fault  output  1  misaligned-fetch flag accompanying id_valid; registered.
REQ-015 id_ready  input  1  decode accepts the instruction this cycle.
REQ-016 redirect  input  1  branch/jump redirect request.
REQ-017 redirect_pc  input  32  redirect target.

Function
REQ-018 FSM states: REQ, WAIT, HOLD, DRAIN; at most one memory transaction outstanding.
REQ-019 REQ: imem_req=1, imem_addr=PC; on imem_ready -> WAIT, latch PC into internal req_pc, nextPC=PC+4 (modulo 2^32, 0xFFFFFFFC wraps to 0).
REQ-020 nextPC=PC in every cycle not covered by REQ-019 or REQ-023 (PC holds).
REQ-021 WAIT: imem_req=0; on imem_rvalid capture id_instr=imem_rdata, id_pc=req_pc, id_valid=1 -> HOLD.
REQ-022 HOLD: id_valid, id_instr, id_pc stable; on id_ready clear id_valid -> REQ; minimum 3 cycles per instruction with zero-wait memory.
REQ-023 redirect has top priority in every state: nextPC=redirect_pc that cycle, id_valid cleared next cycle.
REQ-024 Redirect transitions: REQ without imem_ready -> REQ (no request accepted); REQ with imem_ready -> DRAIN; WAIT without imem_rvalid -> DRAIN; WAIT with imem_rvalid -> REQ, data discarded; HOLD -> REQ (id_ready ignored); DRAIN -> DRAIN.
REQ-025 DRAIN: imem_req=0, id_valid=0; on imem_rvalid discard data -> REQ.
REQ-026 imem_req is forced 0 while reset is asserted.

Reset
REQ-027 On reset: state=REQ, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_fault=0, req_pc=0; takes effect immediately, independent of clk.
REQ-028 Reset mid-transaction abandons any outstanding request; the memory-side response after reset release is ignored unless state is WAIT or DRAIN.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHECK_EN defined: in REQ, if PC[1:0]!=0, imem_req=0, next cycle id_valid=1, id_fault=1, id_instr=NOP_INSTR, id_pc=PC, state HOLD, nextPC=PC; redirect still takes priority.
REQ-030 Macro undefined: imem_addr={PC[31:2],2'b00}, id_fault constant 0, no alignment check logic.

Verification
REQ-031 Reset release, PC=0, imem_ready=1, rvalid one cycle later with 0x00500093, id_ready=1 -> nextPC=4 in REQ cycle, id_valid=1 with id_instr=0x00500093, id_pc=0 two cycles after request.
REQ-032 id_ready=0 for 5 cycles in HOLD -> id_valid/id_instr/id_pc stable, imem_req=0, nextPC=PC throughout.
REQ-033 redirect=1, redirect_pc=0x100 in WAIT, rvalid 3 cycles later -> nextPC=0x100, response discarded, next request address 0x100, no id_valid for stale data.
REQ-034 redirect and imem_rvalid same cycle in WAIT -> state REQ next cycle, id_valid stays 0.
REQ-035 With FETCH_MISALIGN_CHECK_EN, PC=0x102 -> no imem_req, id_valid=1, id_fault=1, id_pc=0x102, id_instr=0x00000013; without macro imem_addr=0x100.
REQ-036 reset asserted in DRAIN -> all outputs to REQ-027 values asynchronously, imem_req=0 until release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, registered decode-side outputs.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] nextPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_reg;
    logic [31:0] req_pc_reg;
    logic        accept;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    logic fault_reg;

    assign misaligned = (PC[1:0] != 2'b00);
    assign imem_req   = (state_reg == S_REQ) && !reset && !misaligned;
    assign imem_addr  = PC;
    assign id_fault   = fault_reg;
`else
    assign imem_req   = (state_reg == S_REQ) && !reset;
    assign imem_addr  = PC & 32'hFFFF_FFFC;
    assign id_fault   = 1'b0;
`endif

    assign accept = imem_req && imem_ready;

    // PC advances only when a request is accepted; a redirect overrides everything.
    always_comb begin
        nextPC = PC;
        if (redirect) begin
            nextPC = redirect_pc;
        end else if (accept) begin
            nextPC = PC + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_REQ;
            req_pc_reg <= 32'd0;
            id_valid   <= 1'b0;
            id_instr   <= NOP_INSTR;
            id_pc      <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (redirect) begin
                        // An accepted request still owes a response that must be swallowed.
                        id_valid <= 1'b0;
                        if (accept) begin
                            state_reg <= S_DRAIN;
                        end
`ifdef FETCH_MISALIGN_CHECK_EN
                    end else if (misaligned) begin
                        id_valid  <= 1'b1;
                        id_instr  <= NOP_INSTR;
                        id_pc     <= PC;
                        fault_reg <= 1'b1;
                        state_reg <= S_HOLD;
`endif
                    end else if (accept) begin
                        req_pc_reg <= PC;
                        state_reg  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        id_valid  <= 1'b0;
                        state_reg <= imem_rvalid ? S_REQ : S_DRAIN;
                    end else if (imem_rvalid) begin
                        id_valid  <= 1'b1;
                        id_instr  <= imem_rdata;
                        id_pc     <= req_pc_reg;
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_reg <= 1'b0;
`endif
                        state_reg <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect || id_ready) begin
                        id_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                        fault_reg <= 1'b0;
`endif
                        state_reg <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    // A redirect here keeps draining; leaving is tied only to the owed response.
                    id_valid <= 1'b0;
                    if (imem_rvalid) begin
                        state_reg <= S_REQ;
                    end
                end
                default: begin
                    id_valid  <= 1'b0;
                    state_reg <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected decode transfers,
// a negedge monitor pops and compares on every id_valid && id_ready.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_reg;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (pc_reg),
        .nextPC     (next_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_fault   (id_fault),
        .id_ready   (id_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    // Program counter register closed around the unit.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_reg <= 32'd0;
        else       pc_reg <= next_pc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && id_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_id: got pc %h instr %h, expected no transfer", id_pc, id_instr);
            end else begin
                mon_e = sb_q.pop_front();
                check("id_instr", id_instr, mon_e.instr);
                check("id_pc", id_pc, mon_e.pc);
                check("id_fault", 32'(id_fault), 32'(mon_e.fault));
                $display("xfer pc=%h instr=%h fault=%0d", id_pc, id_instr, id_fault);
            end
        end
    end

    // Advance one cycle and return inputs to an idle pattern (decode ready).
    task automatic cyc();
        @(posedge clk);
        #1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        id_ready    = 1'b1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic req_wait(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_addr);
        cyc();
        imem_ready = 1'b1;
        settle();
        check("imem_req_req", 32'(imem_req), 32'd1);
        check("imem_addr", imem_addr, exp_addr);
        check("nextPC_req", next_pc, addr + 32'd4);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        settle();
        check("imem_req_wait", 32'(imem_req), 32'd0);
        check("nextPC_wait", next_pc, addr + 32'd4);
        check("id_valid_wait", 32'(id_valid), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int hold,
                         input logic [31:0] exp_addr);
        sb_q.push_back('{instr: data, pc: addr, fault: 1'b0});
        req_wait(addr, data, exp_addr);
        cyc();
        id_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            settle();
            check("hold_valid", 32'(id_valid), 32'd1);
            check("hold_instr", id_instr, data);
            check("hold_pc", id_pc, addr);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_nextPC", next_pc, addr + 32'd4);
            cyc();
            id_ready = 1'b0;
        end
        id_ready = 1'b1;
        settle();
        check("id_valid_hold", 32'(id_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'h00000013);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_fault", 32'(id_fault), 32'd0);
        reset      = 1'b0;
        imem_ready = 1'b0;
        settle();
        check("idle_req", 32'(imem_req), 32'd1);
        check("idle_nextPC", next_pc, 32'd0);

        // Basic fetch, then a decode stall of five cycles.
        fetch(32'h0, 32'h00500093, 0, 32'h0);
        fetch(32'h4, 32'h00a00113, 5, 32'h4);

        // Redirect from HOLD with decode stalled: instruction dropped.
        req_wait(32'h8, 32'h0badf00d, 32'h8);
        cyc();
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        settle();
        check("holdredir_valid", 32'(id_valid), 32'd1);
        check("holdredir_nextPC", next_pc, 32'h40);
        cyc();
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check("holdredir_cleared", 32'(id_valid), 32'd0);
        check("reqredir_req", 32'(imem_req), 32'd1);
        check("reqredir_addr", imem_addr, 32'h40);
        check("reqredir_nextPC", next_pc, 32'hFFFF_FFFC);

        // Wraparound at the top of the address space.
        fetch(32'hFFFF_FFFC, 32'h00000033, 0, 32'hFFFF_FFFC);

        // Redirect while waiting; late response must be discarded.
        cyc();
        imem_ready = 1'b1;
        settle();
        check("r33_addr", imem_addr, 32'h0);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        settle();
        check("r33_nextPC", next_pc, 32'h100);
        check("r33_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            settle();
            check("drain_valid", 32'(id_valid), 32'd0);
            check("drain_req", 32'(imem_req), 32'd0);
            check("drain_nextPC", next_pc, 32'h100);
        end
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdeadbeef;
        settle();
        check("drain_rvalid_req", 32'(imem_req), 32'd0);
        fetch(32'h100, 32'h00108093, 0, 32'h100);

        // Redirect and response in the same WAIT cycle.
        cyc();
        imem_ready = 1'b1;
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hcafef00d;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        settle();
        check("r34_nextPC", next_pc, 32'h200);
        cyc();
        settle();
        check("r34_valid", 32'(id_valid), 32'd0);
        check("r34_req", 32'(imem_req), 32'd1);
        check("r34_addr", imem_addr, 32'h200);
        fetch(32'h200, 32'h00210113, 0, 32'h200);

        // Misaligned fetch address.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        settle();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_nextPC", next_pc, 32'h102);
        sb_q.push_back('{instr: 32'h00000013, pc: 32'h102, fault: 1'b1});
        cyc();
        settle();
        check("mis_valid", 32'(id_valid), 32'd1);
        check("mis_fault", 32'(id_fault), 32'd1);
`else
        check("mis_req", 32'(imem_req), 32'd1);
        check("mis_addr", imem_addr, 32'h100);
        fetch(32'h102, 32'h00318193, 0, 32'h100);
`endif
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h300;

        // Reach DRAIN, then assert reset between clock edges.
        cyc();
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        settle();
        check("r36_req", 32'(imem_req), 32'd1);
        check("r36_nextPC", next_pc, 32'h400);
        cyc();
        imem_ready = 1'b1;
        settle();
        check("r36_drain_req", 32'(imem_req), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_id_instr", id_instr, 32'h00000013);
        check("arst_id_pc", id_pc, 32'd0);
        check("arst_id_valid", 32'(id_valid), 32'd0);
        check("arst_id_fault", 32'(id_fault), 32'd0);
        check("arst_imem_req", 32'(imem_req), 32'd0);
        cyc();
        imem_ready = 1'b1;
        settle();
        check("arst_hold_req", 32'(imem_req), 32'd0);

        // Stale response arriving in REQ after release is ignored.
        cyc();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h12345678;
        settle();
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        cyc();
        settle();
        check("post_rst_valid", 32'(id_valid), 32'd0);
        fetch(32'h0, 32'h00300193, 0, 32'h0);

        cyc();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
